// File: rtl/fc_bus_pkg.sv
// Shared bus constants and the read-controller state type for the FC block.
// Latency: none; this package holds declarations only.
// Backpressure: not applicable.
package fc_bus_pkg;

    localparam int ADDR_W    = 28;
    localparam int BURST_MAX = 16;

    // User IDs carried on AR/AW and echoed on R/B so read and write traffic can share a bus.
    localparam logic [3:0] ARID = 4'b0101;
    localparam logic [3:0] AWID = 4'b0110;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ADDR,
        RD_DATA,
        RD_DONE
    } rd_state_e;

endpackage

// File: rtl/fc_rd_ctrl.sv
// Fetches batch_size*in_size words in 16-beat bursts and hands them to fully_connect as one vector.
// Latency: 2 + sum over bursts of (1 + beats) cycles from the start cycle through the done cycle, zero stalls.
// Backpressure: holds araddr/arlen until arready; beats with a foreign ID are drained without advancing.
module fc_rd_ctrl
    import fc_bus_pkg::*;
#(
    parameter int batch_size = 1,
    parameter int in_size    = 20
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [ADDR_W-1:0]                         NcNrc_initAddr,
    input  logic                                      NcNrc_initAddrEn,
    input  logic                                      NcNrc_start,
    output logic                                      NrcNc_done,
    output logic                                      NrcBus_arvalid,
    input  logic                                      BusNrc_arready,
    output logic [ADDR_W-1:0]                         NrcBus_araddr,
    output logic [3:0]                                NrcBus_arlen,
    output logic [3:0]                                NrcBus_aruser_id,
    output logic                                      NrcBus_aruser_ap,
    input  logic                                      BusNrc_rvalid,
    output logic                                      NrcBus_rready,
    input  logic [31:0]                               BusNrc_rdata,
    input  logic [3:0]                                BusNrc_ruser_id,
    input  logic                                      BusNrc_ruser_last,
    output logic [batch_size-1:0][in_size-1:0][31:0]  NrcFc_data,
    output logic                                      NrcFc_data_en
);

    localparam int N          = batch_size * in_size;
    localparam int BURSTS     = (N + BURST_MAX - 1) / BURST_MAX;
    localparam int LAST_BEATS = N - BURST_MAX * (BURSTS - 1);
    localparam int BI_W       = $clog2(BURSTS) + 1;
    localparam int WI_W       = $clog2(N) + 1;
    localparam int IDX_W      = (N > 1) ? $clog2(N) : 1;

    localparam logic [3:0]      LEN_FULL   = 4'(BURST_MAX - 1);
    localparam logic [3:0]      LEN_LAST   = 4'(LAST_BEATS - 1);
    localparam logic [BI_W-1:0] BURST_LAST = BI_W'(BURSTS - 1);

    rd_state_e           state_q,   state_d;
    logic [ADDR_W-1:0]   base_q,    base_d;
    logic [ADDR_W-1:0]   araddr_q,  araddr_d;
    logic [3:0]          arlen_q,   arlen_d;
    logic [BI_W-1:0]     burst_q,   burst_d;
    logic [4:0]          beat_q,    beat_d;
    logic [WI_W-1:0]     word_q,    word_d;
    logic [N-1:0][31:0]  data_q,    data_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q,  rready_d;
    logic                done_q,    done_d;
    logic                beat_acc;

    // ruser_last is informational only: burst end is taken from our own beat count.
    logic unused_rlast;
    assign unused_rlast = BusNrc_ruser_last;

    // Next-state, address/length generation and beat capture.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        araddr_d = araddr_q;
        arlen_d  = arlen_q;
        burst_d  = burst_q;
        beat_d   = beat_q;
        word_d   = word_q;
        data_d   = data_q;
        beat_acc = 1'b0;

        // The base reloads in any state; the running fetch keeps the copy taken at start.
        if (NcNrc_initAddrEn) begin
            base_d = NcNrc_initAddr;
        end

        case (state_q)
            RD_IDLE: begin
                burst_d = '0;
                beat_d  = '0;
                word_d  = '0;
                if (NcNrc_start) begin
                    state_d  = RD_ADDR;
                    araddr_d = base_q;
                    arlen_d  = (BURSTS == 1) ? LEN_LAST : LEN_FULL;
                end
            end
            RD_ADDR: begin
                if (arvalid_q && BusNrc_arready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                beat_acc = BusNrc_rvalid && (BusNrc_ruser_id == ARID);
                if (beat_acc) begin
                    data_d[word_q[IDX_W-1:0]] = BusNrc_rdata;
                    word_d = word_q + WI_W'(1);
                    if (beat_q == {1'b0, arlen_q}) begin
                        beat_d = '0;
                        if (burst_q == BURST_LAST) begin
                            state_d = RD_DONE;
                        end else begin
                            state_d  = RD_ADDR;
                            burst_d  = burst_q + BI_W'(1);
                            araddr_d = araddr_q + ADDR_W'(BURST_MAX);
                            arlen_d  = (burst_q + BI_W'(1) == BURST_LAST) ? LEN_LAST : LEN_FULL;
                        end
                    end else begin
                        beat_d = beat_q + 5'd1;
                    end
                end
            end
            RD_DONE: begin
                state_d = RD_IDLE;
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase

        // Handshake outputs come straight from flops, decoded from the next state.
        arvalid_d = (state_d == RD_ADDR);
        rready_d  = (state_d == RD_DATA);
        done_d    = (state_d == RD_DONE);
    end

    // State and datapath registers; reset clears everything including the vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RD_IDLE;
            base_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            burst_q   <= '0;
            beat_q    <= '0;
            word_q    <= '0;
            data_q    <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            burst_q   <= burst_d;
            beat_q    <= beat_d;
            word_q    <= word_d;
            data_q    <= data_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            done_q    <= done_d;
        end
    end

    assign NrcBus_arvalid   = arvalid_q;
    assign NrcBus_aruser_ap = arvalid_q;
    assign NrcBus_araddr    = araddr_q;
    assign NrcBus_arlen     = arlen_q;
    assign NrcBus_aruser_id = ARID;
    assign NrcBus_rready    = rready_q;
    assign NrcNc_done       = done_q;
    assign NrcFc_data_en    = done_q;
    assign NrcFc_data       = data_q;

endmodule

// File: tb/tb_fc_rd_ctrl.sv
// Bench for fc_rd_ctrl: two instances (N=20 and N=2x16) share one scripted bus responder.
// Latency: responder answers with zero stall unless an AR stall or foreign beats are requested.
// Backpressure: arready can be held low for a programmed number of arvalid cycles.
module tb_fc_rd_ctrl;

    localparam logic [3:0] ID_RD  = 4'b0101;
    localparam logic [3:0] ID_FGN = 4'b0110;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [27:0] init_addr = '0;
    logic        init_en = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic        sel = 1'b0;
    logic        arready = 1'b1;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic [3:0]  ruser_id = ID_RD;
    logic        rlast = 1'b0;

    logic                    a_done, a_arvalid, a_arap, a_rready, a_en;
    logic [27:0]             a_araddr;
    logic [3:0]              a_arlen, a_arid;
    logic [0:0][19:0][31:0]  a_data;
    logic                    b_done, b_arvalid, b_arap, b_rready, b_en;
    logic [27:0]             b_araddr;
    logic [3:0]              b_arlen, b_arid;
    logic [1:0][15:0][31:0]  b_data;

    always #5 clk = ~clk;

    fc_rd_ctrl #(.batch_size(1), .in_size(20)) u_a (
        .clk(clk), .rst_n(rst_n), .NcNrc_initAddr(init_addr), .NcNrc_initAddrEn(init_en),
        .NcNrc_start(start_a), .NrcNc_done(a_done), .NrcBus_arvalid(a_arvalid),
        .BusNrc_arready(arready && !sel), .NrcBus_araddr(a_araddr), .NrcBus_arlen(a_arlen),
        .NrcBus_aruser_id(a_arid), .NrcBus_aruser_ap(a_arap), .BusNrc_rvalid(rvalid && !sel),
        .NrcBus_rready(a_rready), .BusNrc_rdata(rdata), .BusNrc_ruser_id(ruser_id),
        .BusNrc_ruser_last(rlast), .NrcFc_data(a_data), .NrcFc_data_en(a_en)
    );

    fc_rd_ctrl #(.batch_size(2), .in_size(16)) u_b (
        .clk(clk), .rst_n(rst_n), .NcNrc_initAddr(init_addr), .NcNrc_initAddrEn(init_en),
        .NcNrc_start(start_b), .NrcNc_done(b_done), .NrcBus_arvalid(b_arvalid),
        .BusNrc_arready(arready && sel), .NrcBus_araddr(b_araddr), .NrcBus_arlen(b_arlen),
        .NrcBus_aruser_id(b_arid), .NrcBus_aruser_ap(b_arap), .BusNrc_rvalid(rvalid && sel),
        .NrcBus_rready(b_rready), .BusNrc_rdata(rdata), .BusNrc_ruser_id(ruser_id),
        .BusNrc_ruser_last(rlast), .NrcFc_data(b_data), .NrcFc_data_en(b_en)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Responder model state.
    logic        s_arvalid, s_rready, s_done, s_en;
    logic [27:0] s_araddr;
    logic [3:0]  s_arlen;
    logic [27:0] ar_addr_log[$];
    logic [3:0]  ar_len_log[$];
    int          beats_left = 0;
    logic [27:0] cur_addr = '0;
    bit          fgn_mode = 1'b0;
    bit          fgn_next = 1'b0;
    int          stall_left = 0;
    int          unstable = 0;
    int          nbeats = 0;

    typedef struct {
        bit          sel;
        logic [27:0] base;
        int          stall;
        bit          fgn;
        int          nb;
        logic [27:0] a0;
        logic [3:0]  l0;
        logic [27:0] a1;
        logic [3:0]  l1;
        int          lat;
    } vec_t;

    vec_t tbl[4];

    function automatic logic [31:0] word(input logic [27:0] a);
        return {4'hC, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic int data_errs(input bit sl, input logic [27:0] base);
        int m;
        m = 0;
        for (int k = 0; k < (sl ? 32 : 20); k++) begin
            logic [27:0] ad;
            logic [31:0] got;
            ad  = base + 28'(k);
            got = sl ? b_data[k / 16][k % 16] : a_data[0][k];
            if (got !== word(ad)) m++;
        end
        return m;
    endfunction

    task automatic sample();
        s_arvalid = sel ? b_arvalid : a_arvalid;
        s_rready  = sel ? b_rready  : a_rready;
        s_done    = sel ? b_done    : a_done;
        s_en      = sel ? b_en      : a_en;
        s_araddr  = sel ? b_araddr  : a_araddr;
        s_arlen   = sel ? b_arlen   : a_arlen;
    endtask

    task automatic drive_beat();
        if (beats_left > 0) begin
            rvalid = 1'b1;
            if (fgn_next) begin
                ruser_id = ID_FGN;
                rdata    = 32'hDEAD_BEEF;
                rlast    = 1'b0;
            end else begin
                ruser_id = ID_RD;
                rdata    = word(cur_addr);
                rlast    = (beats_left == 1);
            end
        end else begin
            rvalid   = 1'b0;
            ruser_id = ID_RD;
            rdata    = '0;
            rlast    = 1'b0;
        end
    endtask

    // One clock: resolve handshakes that happen on this edge, then drive the next cycle.
    task automatic step();
        logic        ar_hs, r_hs, was_waiting;
        logic [27:0] p_addr;
        logic [3:0]  p_len;
        ar_hs = s_arvalid && arready;
        r_hs  = s_rready && rvalid;
        was_waiting = s_arvalid && !ar_hs;
        p_addr = s_araddr;
        p_len  = s_arlen;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        init_en = 1'b0;
        if (ar_hs) begin
            ar_addr_log.push_back(p_addr);
            ar_len_log.push_back(p_len);
            beats_left = int'(p_len) + 1;
            cur_addr   = p_addr;
            fgn_next   = fgn_mode;
        end
        if (r_hs) begin
            if (ruser_id == ID_RD) begin
                beats_left--;
                cur_addr = cur_addr + 28'd1;
                fgn_next = fgn_mode;
                nbeats++;
            end else begin
                fgn_next = 1'b0;
            end
        end
        sample();
        if (was_waiting && s_arvalid && (s_araddr != p_addr || s_arlen != p_len)) unstable++;
        if (s_arvalid && stall_left > 0) begin
            arready = 1'b0;
            stall_left--;
        end else begin
            arready = 1'b1;
        end
        drive_beat();
    endtask

    // Step until done (bounded); n is the number of edges from the start edge to done visible.
    task automatic fetch(input string tag, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!s_done && n < 400);
        chk({tag, " done seen"}, 64'(s_done), 64'(1));
        chk({tag, " data_en with done"}, 64'(s_en), 64'(1));
        step();
        chk({tag, " done/en one cycle"}, 64'({s_done, s_en}), 64'(0));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " arvalid"}, 64'(a_arvalid), 64'(0));
        chk({tag, " rready"}, 64'(a_rready), 64'(0));
        chk({tag, " aruser_ap"}, 64'(a_arap), 64'(0));
        chk({tag, " done/en"}, 64'({a_done, a_en}), 64'(0));
        chk({tag, " araddr"}, 64'(a_araddr), 64'(0));
        chk({tag, " arlen"}, 64'(a_arlen), 64'(0));
        chk({tag, " aruser_id"}, 64'(a_arid), 64'(ID_RD));
        chk({tag, " data zero"}, 64'(a_data != '0), 64'(0));
    endtask

    task automatic clear_log();
        ar_addr_log.delete();
        ar_len_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int arv;
        vec_t v;

        // Expected latency counts the start cycle through the done cycle: 2 + sum(1 + beats) + stalls.
        tbl[0] = '{1'b0, 28'h0000100, 0, 1'b0, 2, 28'h0000100, 4'd15, 28'h0000110, 4'd3, 24};
        tbl[1] = '{1'b0, 28'hFFFFFF8, 5, 1'b0, 2, 28'hFFFFFF8, 4'd15, 28'h0000008, 4'd3, 29};
        tbl[2] = '{1'b0, 28'h0002345, 0, 1'b1, 2, 28'h0002345, 4'd15, 28'h0002355, 4'd3, 44};
        tbl[3] = '{1'b1, 28'h0000400, 0, 1'b0, 2, 28'h0000400, 4'd15, 28'h0000410, 4'd15, 36};

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;
        sample();

        for (int i = 0; i < 4; i++) begin
            string tag;
            v   = tbl[i];
            tag = $sformatf("v%0d", i);
            sel = v.sel;
            fgn_mode   = v.fgn;
            stall_left = v.stall;
            unstable   = 0;
            clear_log();
            sample();
            init_addr = v.base;
            init_en   = 1'b1;
            step();
            start_a = !v.sel;
            start_b = v.sel;
            fetch(tag, n);
            chk({tag, " ar count"}, 64'(ar_addr_log.size()), 64'(v.nb));
            chk({tag, " ar0 addr"}, 64'(ar_addr_log[0]), 64'(v.a0));
            chk({tag, " ar0 len"}, 64'(ar_len_log[0]), 64'(v.l0));
            chk({tag, " ar1 addr"}, 64'(ar_addr_log[1]), 64'(v.a1));
            chk({tag, " ar1 len"}, 64'(ar_len_log[1]), 64'(v.l1));
            chk({tag, " latency"}, 64'(n + 1), 64'(v.lat));
            chk({tag, " ar stable"}, 64'(unstable), 64'(0));
            chk({tag, " data word errors"}, 64'(data_errs(v.sel, v.base)), 64'(0));
        end
        fgn_mode = 1'b0;

        // Base reload mid-fetch only affects the following fetch.
        sel = 1'b0;
        sample();
        clear_log();
        init_addr = 28'h100;
        init_en   = 1'b1;
        step();
        start_a = 1'b1;
        step();
        step();
        step();
        init_addr = 28'h200;
        init_en   = 1'b1;
        fetch("reload f1", n);
        chk("reload f1 ar0", 64'(ar_addr_log[0]), 64'(28'h100));
        chk("reload f1 ar1", 64'(ar_addr_log[1]), 64'(28'h110));
        chk("reload f1 data", 64'(data_errs(1'b0, 28'h100)), 64'(0));
        clear_log();
        start_a = 1'b1;
        fetch("reload f2", n);
        chk("reload f2 ar0", 64'(ar_addr_log[0]), 64'(28'h200));
        chk("reload f2 ar1", 64'(ar_addr_log[1]), 64'(28'h210));
        chk("reload f2 data", 64'(data_errs(1'b0, 28'h200)), 64'(0));

        // Reset while beat 7 of burst 0 is on the bus, then refetch from the cleared base.
        clear_log();
        init_addr = 28'h100;
        init_en   = 1'b1;
        step();
        nbeats  = 0;
        start_a = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (nbeats < 7 && n < 100);
        chk("midreset beat7 presented", 64'({rvalid, s_rready}), 64'(2'b11));
        rst_n = 1'b0;
        #1;
        chk_reset("midreset");
        #2 rst_n = 1'b1;
        beats_left = 0;
        drive_beat();
        sample();
        clear_log();
        start_a = 1'b1;
        fetch("postreset", n);
        chk("postreset ar0", 64'(ar_addr_log[0]), 64'(0));
        chk("postreset ar1", 64'(ar_addr_log[1]), 64'(28'h10));
        chk("postreset data", 64'(data_errs(1'b0, 28'h0)), 64'(0));

        // N=32 with a start pulse while busy: exactly one fetch of two full bursts.
        sel = 1'b1;
        sample();
        clear_log();
        init_addr = 28'h400;
        init_en   = 1'b1;
        step();
        start_b = 1'b1;
        step();
        step();
        step();
        start_b = 1'b1;
        fetch("busy", n);
        chk("busy latency", 64'(3 + n + 1), 64'(36));
        chk("busy ar count", 64'(ar_addr_log.size()), 64'(2));
        chk("busy ar1 len", 64'(ar_len_log[1]), 64'(15));
        chk("busy data[1][0]", 64'(b_data[1][0]), 64'(word(28'h410)));
        arv = 0;
        repeat (5) begin
            step();
            if (s_arvalid) arv++;
        end
        chk("busy no refetch", 64'(arv), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
